// File: rtl/mem_responder_pkg.sv
// Shared definitions for the CPU memory interface: command codes, I/O port
// addresses, responder FSM states and the address decoder.
package mem_responder_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RG_RAM  = 2'd0,
        RG_LED  = 2'd1,
        RG_SW   = 2'd2,
        RG_NONE = 2'd3
    } region_e;

    function automatic region_e decode_addr(input logic [8:0] addr);
        region_e rg;
        if (addr[8] == 1'b0) begin
            rg = RG_RAM;
        end else if (addr == LED_ADDR) begin
            rg = RG_LED;
        end else if (addr == SW_ADDR) begin
            rg = RG_SW;
        end else begin
            rg = RG_NONE;
        end
        return rg;
    endfunction

endpackage

// File: rtl/mem_responder_ram_sp.sv
// Single-port word RAM: synchronous write, combinational read of the same
// address so read data is available in the cycle the address is presented.
module ram_sp #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: RAM, LED register and switch port behind a small
// request FSM with programmable read latency and ack/err pulses.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 9,
    parameter int RAM_WORDS = 256,
    parameter int READ_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ack,
    output logic              mem_err,
    input  logic [7:0]        sw_in,
    output logic [7:0]        led_out
);

    localparam int         RAM_AW   = $clog2(RAM_WORDS);
    localparam logic [2:0] LAT_LOAD = (READ_LAT > 1) ? 3'(READ_LAT - 2) : 3'd0;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        cnt_q;
    logic [DATA_W-1:0] read_data_q;
    logic              ack_q;
    logic              err_q;
    logic [7:0]        led_q;
    logic [7:0]        sync1_q;
    logic [7:0]        sync2_q;

    logic [ADDR_W-1:0] eff_addr_s;
    region_e           region_s;
    logic              ram_we_s;
    logic [DATA_W-1:0] ram_rdata_s;
    logic [DATA_W-1:0] rd_value_s;
    logic              rd_err_s;
    logic              wr_err_s;

    // In IDLE the live bus address is decoded; afterwards the latched one.
    assign eff_addr_s = (state_q == ST_IDLE) ? mem_addr : addr_q;
    assign region_s   = decode_addr(eff_addr_s);
    assign ram_we_s   = (state_q == ST_IDLE) && (mem_cmd == MWRITE) && (region_s == RG_RAM);
    assign rd_err_s   = (region_s != RG_RAM) && (region_s != RG_SW);
    assign wr_err_s   = (region_s != RG_RAM) && (region_s != RG_LED);

    // Read mux: unmapped and write-only addresses read back as zero.
    always_comb begin
        rd_value_s = {DATA_W{1'b0}};
        case (region_s)
            RG_RAM:  rd_value_s = ram_rdata_s;
            RG_SW:   rd_value_s = {{(DATA_W-8){1'b0}}, sync2_q};
            default: rd_value_s = {DATA_W{1'b0}};
        endcase
    end

    ram_sp #(
        .WIDTH (DATA_W),
        .DEPTH (RAM_WORDS)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .addr_i  (eff_addr_s[RAM_AW-1:0]),
        .wdata_i (write_data),
        .rdata_o (ram_rdata_s)
    );

    // Request FSM, registered ack/err/read data, LED register and switch synchroniser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            cnt_q       <= 3'd0;
            read_data_q <= {DATA_W{1'b0}};
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            led_q       <= 8'd0;
            sync1_q     <= 8'd0;
            sync2_q     <= 8'd0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mem_cmd == MWRITE) begin
                        state_q <= ST_RESP;
                        ack_q   <= 1'b1;
                        err_q   <= wr_err_s;
                        if (region_s == RG_LED) begin
                            led_q <= write_data[7:0];
                        end
                    end else if (mem_cmd == MREAD) begin
                        addr_q <= mem_addr;
                        if (READ_LAT == 1) begin
                            state_q     <= ST_RESP;
                            ack_q       <= 1'b1;
                            err_q       <= rd_err_s;
                            read_data_q <= rd_value_s;
                        end else begin
                            cnt_q   <= LAT_LOAD;
                            state_q <= ST_WAIT;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q     <= ST_RESP;
                        ack_q       <= 1'b1;
                        err_q       <= rd_err_s;
                        read_data_q <= rd_value_s;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign read_data = read_data_q;
    assign mem_ack   = ack_q;
    assign mem_err   = err_q;
    assign led_out   = led_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances with read latencies
// 1, 3 and 4 share clock and reset; expectations are queued per instance.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int NDUT = 3;
    localparam int LATS [NDUT] = '{1, 3, 4};

    typedef struct {
        logic        is_read;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [7:0]  sw_in;
    logic [1:0]  cmd   [NDUT];
    logic [8:0]  addr  [NDUT];
    logic [15:0] wdata [NDUT];
    logic [15:0] rdata [NDUT];
    logic        ack   [NDUT];
    logic        err   [NDUT];
    logic [7:0]  led   [NDUT];

    exp_t sb_q [NDUT][$];
    exp_t mon_e;
    logic prev_ack [NDUT];
    int   n_checks = 0;
    int   n_fail   = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_responder #(.READ_LAT(LATS[g])) u_dut (
            .clk        (clk),
            .reset      (reset),
            .mem_cmd    (cmd[g]),
            .mem_addr   (addr[g]),
            .write_data (wdata[g]),
            .read_data  (rdata[g]),
            .mem_ack    (ack[g]),
            .mem_err    (err[g]),
            .sw_in      (sw_in),
            .led_out    (led[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitor: every ack pops one expectation.
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (reset && ack[i] === 1'b1) begin
                check_value("ack_single_pulse", {31'd0, prev_ack[i]}, 32'd0);
                if (sb_q[i].size() == 0) begin
                    check_value("unexpected_ack", {31'd0, ack[i]}, 32'd0);
                end else begin
                    mon_e = sb_q[i].pop_front();
                    if (mon_e.is_read) check_value("read_data", {16'd0, rdata[i]}, {16'd0, mon_e.rdata});
                    check_value("mem_err", {31'd0, err[i]}, {31'd0, mon_e.err});
                end
            end else if (reset && err[i] === 1'b1) begin
                check_value("err_without_ack", {31'd0, err[i]}, 32'd0);
            end
            prev_ack[i] = ack[i];
        end
    end

    task automatic access(input int d, input logic [1:0] c, input logic [8:0] a,
                          input logic [15:0] wd, input logic [15:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        int   lat;
        e.is_read = (c == MREAD);
        e.rdata   = exp_rd;
        e.err     = exp_err;
        lat = (c == MREAD) ? LATS[d] : 1;
        @(posedge clk);
        #1;
        cmd[d]   = c;
        addr[d]  = a;
        wdata[d] = wd;
        sb_q[d].push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack[d] !== 1'b1 && n < 20);
        check_value("ack_latency", n - 1, lat);
        cmd[d] = MNONE;
    endtask

    initial begin
        exp_t e;
        int   n;
        reset = 1'b0;
        sw_in = 8'h00;
        for (int i = 0; i < NDUT; i++) begin
            cmd[i] = MNONE; addr[i] = 9'h000; wdata[i] = 16'h0000; prev_ack[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check_value("rst_read_data", {16'd0, rdata[i]}, 32'd0);
            check_value("rst_ack", {31'd0, ack[i]}, 32'd0);
            check_value("rst_led", {24'd0, led[i]}, 32'd0);
        end

        // Reset during WAIT on the latency-3 instance aborts the read.
        @(posedge clk);
        #1 cmd[1] = MREAD; addr[1] = 9'h005;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cmd[1] = MNONE;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check_value("abort_ack", {31'd0, ack[1]}, 32'd0);
        check_value("abort_read_data", {16'd0, rdata[1]}, 32'd0);
        check_value("abort_led", {24'd0, led[1]}, 32'd0);

        // Latency 3 after reset: instance back in IDLE.
        access(1, MWRITE, 9'h010, 16'hCAFE, 16'h0000, 1'b0);
        access(1, MREAD,  9'h010, 16'h0000, 16'hCAFE, 1'b0);

        // Latency 1 instance: RAM, LED, switch port, unmapped.
        access(0, MWRITE, 9'h005, 16'hBEEF, 16'h0000, 1'b0);
        access(0, MREAD,  9'h005, 16'h0000, 16'hBEEF, 1'b0);
        access(0, MWRITE, LED_ADDR, 16'h00A5, 16'h0000, 1'b0);
        check_value("led_on_ack", {24'd0, led[0]}, 32'h0000_00A5);
        access(0, MREAD,  LED_ADDR, 16'h0000, 16'h0000, 1'b1);
        sw_in = 8'h3C;
        repeat (3) @(posedge clk);
        access(0, MREAD,  SW_ADDR, 16'h0000, 16'h003C, 1'b0);
        access(0, MWRITE, SW_ADDR, 16'hFFFF, 16'h0000, 1'b1);
        check_value("led_unchanged", {24'd0, led[0]}, 32'h0000_00A5);
        check_value("read_data_held_after_werr", {16'd0, rdata[0]}, 32'h0000_003C);
        access(0, MREAD,  9'h1F0, 16'h0000, 16'h0000, 1'b1);

        // Back-to-back reads with the command held across RESP.
        e.is_read = 1'b1; e.rdata = 16'hBEEF; e.err = 1'b0;
        sb_q[0].push_back(e);
        sb_q[0].push_back(e);
        @(posedge clk);
        #1 cmd[0] = MREAD; addr[0] = 9'h005;
        n = 0;
        do begin @(negedge clk); n++; end while (ack[0] !== 1'b1 && n < 20);
        check_value("b2b_first_latency", n - 1, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (ack[0] !== 1'b1 && n < 20);
        check_value("b2b_gap", n, 2);
        cmd[0] = MNONE;

        // Latency 4 instance: long read, data held across a later write.
        access(2, MWRITE, 9'h0FF, 16'h1234, 16'h0000, 1'b0);
        access(2, MREAD,  9'h0FF, 16'h0000, 16'h1234, 1'b0);
        access(2, MWRITE, 9'h0FF, 16'h5555, 16'h0000, 1'b0);
        check_value("read_data_held_after_write", {16'd0, rdata[2]}, 32'h0000_1234);
        access(2, MREAD,  9'h0FF, 16'h0000, 16'h5555, 1'b0);
        access(2, MREAD,  9'h1F0, 16'h0000, 16'h0000, 1'b1);

        repeat (4) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check_value("scoreboard_drained", sb_q[i].size(), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side endpoint of the CPU memory interface. Samples mem_cmd, mem_addr and write_data from the CPU, and returns read_data.
- Contains a 256x16 word RAM, a memory-mapped LED output register and a synchronised switch input port.
- Uses a small request FSM with programmable read latency. An ack pulse lets the CPU FSM wait on completion instead of counting states.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 9, address width; matches mem_addr.
- RAM_WORDS, 256, RAM depth; decoded when mem_addr[8]==0.
- READ_LAT, 1, cycles from MREAD acceptance to ack (valid range 1..7).
- LED_ADDR, 9'h100, write-only LED register address.
- SW_ADDR, 9'h140, read-only switch port address.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low. Asserted when 0.
- mem_cmd, input, 2: 2'b00 MNONE, 2'b01 MREAD, 2'b10 MWRITE, 2'b11 reserved (treated as MNONE).
- mem_addr, input, ADDR_W: word address.
- write_data, input, DATA_W: store data, sampled with MWRITE.
- read_data, output, DATA_W: load data, valid while mem_ack is high and held until the next read completes.
- mem_ack, output, 1: one-cycle pulse when a read or write completes.
- mem_err, output, 1: one-cycle pulse, coincident with mem_ack, when the access hits an unmapped address or a wrong-direction port.
- sw_in, input, 8: asynchronous switches.
- led_out, output, 8: LED register.

Behaviour:
- Reset (reset==0, asynchronous):
  - FSM goes to IDLE.
  - read_data=0, mem_ack=0, mem_err=0, led_out=0, switch synchroniser flops=0.
  - RAM contents are not reset.
  - Reset mid-request aborts the request; no write is performed after reset deasserts.
- FSM states IDLE, WAIT, RESP. A 3-bit latency counter is used in WAIT.
- IDLE:
  - MWRITE sampled: perform the write at this edge and go to RESP. mem_ack rises the next cycle, so write latency is 1.
  - MREAD sampled: latch address. If READ_LAT==1, go to RESP; otherwise load counter=READ_LAT-2 and go to WAIT.
  - MNONE or 2'b11: stay in IDLE.
- WAIT: decrement the counter each cycle. Go to RESP when counter==0. Commands presented in WAIT are ignored; the CPU must hold the command until ack.
- RESP:
  - mem_ack=1 for exactly one cycle. For reads, read_data is updated on the edge entering RESP.
  - Next state is IDLE. Commands sampled during RESP are ignored, so there is one idle bubble between requests.
- Address decode, using the latched address:
  - mem_addr[8]==0: RAM word mem_addr[7:0].
  - mem_addr==LED_ADDR: MWRITE loads led_out from write_data[7:0]. MREAD returns 0 and raises err.
  - mem_addr==SW_ADDR: MREAD returns {8'b0, sw_sync}. MWRITE is ignored and raises err.
  - Any other address: reads return 0, writes are dropped, err is raised.
- Switch synchroniser: 2-flop chain, free-running every cycle. The read value is sampled when entering RESP.
- A read immediately after a write to the same address returns the new data (no hazard, because of the bubble).
- read_data is not changed by writes or errors-on-write. A read error sets read_data to 0.

Decomposition:
- Shared package/header: constants MNONE/MREAD/MWRITE (2-bit), LED_ADDR, SW_ADDR, state encodings IDLE/WAIT/RESP.
- The CPU side uses the same mem_cmd constants.
- One sub-module: ram_sp (single-port synchronous-write RAM, parameterised width and depth, read in the same cycle as address is latched).
- The FSM, decode and I/O registers stay in mem_responder.

Test Plan:
- Reset=0 mid-read (READ_LAT=3, reset during WAIT), then release -> read_data=0, mem_ack=0, led_out=0, FSM in IDLE, no ack issued.
- MWRITE addr 9'h005 data 16'hBEEF, then MREAD 9'h005 with READ_LAT=1 -> ack one cycle after each command, read_data=16'hBEEF on the second ack, err=0.
- READ_LAT=4: MREAD 9'h0FF after writing 16'h1234 -> ack exactly 4 cycles after acceptance, read_data=16'h1234, held until the next read.
- MWRITE LED_ADDR data 16'h00A5 -> led_out=8'hA5 from the ack cycle onward. Then MREAD LED_ADDR -> read_data=0 and err pulse.
- sw_in=8'h3C stable for 3 cycles, then MREAD SW_ADDR -> read_data=16'h003C. MWRITE SW_ADDR -> err pulse, led_out unchanged.
- MREAD 9'h1F0 (unmapped) -> ack with err=1 and read_data=0. Back-to-back MREAD held across RESP -> exactly one bubble cycle, then a second ack.
